// File: rtl/iir_dac_output_stage_pkg.sv
// Shared definitions for the IIR DAC output stage: state encoding and the
// signed clamp used between the offset adder and the slew limiter.
package iir_dac_output_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_RAMP_DOWN = 2'd2
    } state_e;

    // Wide enough for any DATA_WIDTH+1 sum to be compared without wrap.
    localparam int CLAMP_W = 32;

    function automatic logic signed [CLAMP_W-1:0] clamp_s(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/iir_dac_output_stage_if.sv
// GPIO-side configuration, filter sample input and DAC/status outputs of the
// output stage, bundled so the driver and the stage share one port list.
interface iir_dac_output_stage_if
    import iir_dac_output_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 14,
    parameter int STEP_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic signed [DATA_WIDTH-1:0] y_in;
    logic signed [DATA_WIDTH-1:0] offset;
    logic signed [DATA_WIDTH-1:0] lim_lo;
    logic signed [DATA_WIDTH-1:0] lim_hi;
    logic        [STEP_WIDTH-1:0] max_step;
    logic                         enable;
    logic                         hold;
    logic                         sat_clr;

    logic signed [OUT_WIDTH-1:0]  dac_out;
    state_e                       state;
    logic                         sat_hi;
    logic                         sat_lo;
    logic                         cfg_err;
    logic        [CNT_WIDTH-1:0]  sat_count;

    modport master (
        output y_in, offset, lim_lo, lim_hi, max_step, enable, hold, sat_clr,
        input  dac_out, state, sat_hi, sat_lo, cfg_err, sat_count
    );

    modport slave (
        input  y_in, offset, lim_lo, lim_hi, max_step, enable, hold, sat_clr,
        output dac_out, state, sat_hi, sat_lo, cfg_err, sat_count
    );

endinterface

// File: rtl/iir_dac_output_stage_slew_limiter.sv
// Slew-rate limited accumulator: moves acc toward tgt by at most max_step per
// clock (0 = jump straight to tgt), with freeze (hold) and force-to-zero (clear).
module iir_dac_output_stage_slew_limiter #(
    parameter int DATA_WIDTH = 16,
    parameter int STEP_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         hold_i,
    input  logic signed [DATA_WIDTH-1:0] tgt_i,
    input  logic        [STEP_WIDTH-1:0] max_step_i,
    output logic signed [DATA_WIDTH-1:0] acc_o
);

    // Difference needs DATA_WIDTH+2 bits; the step must also fit as a positive value.
    localparam int W = (DATA_WIDTH + 2 > STEP_WIDTH + 1) ? DATA_WIDTH + 2 : STEP_WIDTH + 1;

    logic signed [DATA_WIDTH-1:0] acc_q;
    logic signed [DATA_WIDTH-1:0] acc_d;
    logic signed [W-1:0]          tgt_w;
    logic signed [W-1:0]          acc_w;
    logic signed [W-1:0]          step_w;
    logic signed [W-1:0]          diff;
    logic signed [W-1:0]          mag;

    assign tgt_w  = W'(tgt_i);
    assign acc_w  = W'(acc_q);
    assign step_w = W'(max_step_i);
    assign diff   = tgt_w - acc_w;
    assign mag    = diff[W-1] ? -diff : diff;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (!hold_i) begin
            if ((max_step_i == '0) || (mag <= step_w)) begin
                acc_d = tgt_i;
            end else if (diff[W-1]) begin
                acc_d = DATA_WIDTH'(acc_w - step_w);
            end else begin
                acc_d = DATA_WIDTH'(acc_w + step_w);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/iir_dac_output_stage.sv
// DAC output stage after the IIR filter: offset, clamp, slew limit and
// enable-driven ramp up/down so the actuator never sees a step.
module iir_dac_output_stage
    import iir_dac_output_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 14,
    parameter int STEP_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    iir_dac_output_stage_if.slave    bus
);

    localparam int SUM_W = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e                       state_q;
    logic signed [SUM_W-1:0]      sum_q;
    logic signed [SUM_W-1:0]      sum_d;
    logic signed [DATA_WIDTH-1:0] tgt_q;
    logic signed [DATA_WIDTH-1:0] tgt_d;
    logic                         sat_hi_q;
    logic                         sat_hi_d;
    logic                         sat_lo_q;
    logic                         sat_lo_d;
    logic                         cfg_err_q;
    logic                         cfg_bad;
    logic signed [OUT_WIDTH-1:0]  dac_q;
    logic        [CNT_WIDTH-1:0]  sat_count_q;
    logic        [CNT_WIDTH-1:0]  sat_count_d;
    logic signed [DATA_WIDTH-1:0] eff_tgt;
    logic signed [DATA_WIDTH-1:0] acc;
    logic signed [CLAMP_W-1:0]    sum_w;
    logic signed [CLAMP_W-1:0]    lo_w;
    logic signed [CLAMP_W-1:0]    hi_w;

    assign sum_d = {bus.y_in[DATA_WIDTH-1], bus.y_in} + {bus.offset[DATA_WIDTH-1], bus.offset};

    assign sum_w   = CLAMP_W'(sum_q);
    assign lo_w    = CLAMP_W'(bus.lim_lo);
    assign hi_w    = CLAMP_W'(bus.lim_hi);
    assign cfg_bad = (bus.lim_lo > bus.lim_hi);
    assign tgt_d   = cfg_bad ? '0 : DATA_WIDTH'(clamp_s(sum_w, lo_w, hi_w));

    // The next state is RUN exactly when enable is high, so gating with enable
    // keeps the registered flags aligned with state_q being RUN.
    assign sat_hi_d = bus.enable & ~cfg_bad & (sum_w > hi_w);
    assign sat_lo_d = bus.enable & ~cfg_bad & (sum_w < lo_w);

    always_comb begin
        sat_count_d = sat_count_q;
        if (bus.sat_clr) begin
            sat_count_d = '0;
        end else if ((sat_hi_q || sat_lo_q) && (sat_count_q != CNT_MAX)) begin
            sat_count_d = sat_count_q + 1'b1;
        end
    end

    assign eff_tgt = (state_q == ST_RUN) ? tgt_q : '0;

    iir_dac_output_stage_slew_limiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_slew (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_q == ST_IDLE),
        .hold_i     (bus.hold),
        .tgt_i      (eff_tgt),
        .max_step_i (bus.max_step),
        .acc_o      (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            tgt_q       <= '0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            dac_q       <= '0;
            sat_count_q <= '0;
        end else begin
            sum_q       <= sum_d;
            tgt_q       <= tgt_d;
            sat_hi_q    <= sat_hi_d;
            sat_lo_q    <= sat_lo_d;
            cfg_err_q   <= cfg_bad;
            dac_q       <= acc[DATA_WIDTH-1 -: OUT_WIDTH];
            sat_count_q <= sat_count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!bus.enable) state_q <= ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (bus.enable) begin
                        state_q <= ST_RUN;
                    end else if (acc == '0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dac_out   = dac_q;
    assign bus.state     = state_q;
    assign bus.sat_hi    = sat_hi_q;
    assign bus.sat_lo    = sat_lo_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.sat_count = sat_count_q;

endmodule

// File: tb/tb_iir_dac_output_stage.sv
// Bench for the DAC output stage: directed scenarios plus random traffic,
// all checked against a cycle-level arithmetic model of the stage.
module tb_iir_dac_output_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iir_dac_output_stage_if bus ();

    iir_dac_output_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: 0 IDLE, 1 RUN, 2 RAMP_DOWN
    int m_sum, m_tgt, m_acc, m_dac, m_state, m_cnt;
    bit m_sh, m_sl, m_cfg;

    task automatic model_reset();
        m_sum = 0; m_tgt = 0; m_acc = 0; m_dac = 0; m_state = 0; m_cnt = 0;
        m_sh = 0; m_sl = 0; m_cfg = 0;
    endtask

    // Advance one clock; the model computes what every register should hold.
    task automatic tick();
        int y, o, lo, hi, st, eff, d, ad;
        int n_sum, n_tgt, n_acc, n_dac, n_state, n_cnt;
        bit cfg, n_sh, n_sl;
        y  = int'(bus.y_in);
        o  = int'(bus.offset);
        lo = int'(bus.lim_lo);
        hi = int'(bus.lim_hi);
        st = int'(bus.max_step);
        cfg   = (lo > hi);
        n_sum = y + o;
        if (cfg)             n_tgt = 0;
        else if (m_sum > hi) n_tgt = hi;
        else if (m_sum < lo) n_tgt = lo;
        else                 n_tgt = m_sum;
        n_sh = bus.enable && !cfg && (m_sum > hi);
        n_sl = bus.enable && !cfg && (m_sum < lo);
        if (bus.sat_clr)                      n_cnt = 0;
        else if ((m_sh || m_sl) && m_cnt < 65535) n_cnt = m_cnt + 1;
        else                                  n_cnt = m_cnt;
        eff = (m_state == 1) ? m_tgt : 0;
        if (m_state == 0)  n_acc = 0;
        else if (bus.hold) n_acc = m_acc;
        else begin
            d  = eff - m_acc;
            ad = (d < 0) ? -d : d;
            if (st == 0 || ad <= st) n_acc = eff;
            else                     n_acc = (d > 0) ? m_acc + st : m_acc - st;
        end
        n_dac = m_acc >>> 2;
        case (m_state)
            0:       n_state = bus.enable ? 1 : 0;
            1:       n_state = bus.enable ? 1 : 2;
            default: n_state = bus.enable ? 1 : ((m_acc == 0) ? 0 : 2);
        endcase
        @(posedge clk);
        m_sum = n_sum; m_tgt = n_tgt; m_acc = n_acc; m_dac = n_dac;
        m_state = n_state; m_cnt = n_cnt; m_sh = n_sh; m_sl = n_sl; m_cfg = cfg;
        #1;
    endtask

    task automatic test_reset();
        bus.y_in = '0; bus.offset = '0; bus.lim_lo = -16'sd32767; bus.lim_hi = 16'sd32767;
        bus.max_step = '0; bus.enable = 1'b0; bus.hold = 1'b0; bus.sat_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks += 6;
        if (bus.dac_out !== 14'sd0) begin errors++; $display("FAIL reset dac_out: got %0d expected 0", bus.dac_out); end
        if (bus.state !== 2'd0) begin errors++; $display("FAIL reset state: got %0d expected 0", bus.state); end
        if (bus.sat_hi !== 1'b0) begin errors++; $display("FAIL reset sat_hi: got %0b expected 0", bus.sat_hi); end
        if (bus.sat_lo !== 1'b0) begin errors++; $display("FAIL reset sat_lo: got %0b expected 0", bus.sat_lo); end
        if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset cfg_err: got %0b expected 0", bus.cfg_err); end
        if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL reset sat_count: got %0d expected 0", bus.sat_count); end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_latency();
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.state !== 2'd1) begin errors++; $display("FAIL enter_run state: got %0d expected 1", bus.state); end
        repeat (3) tick();
        bus.y_in = 16'sh1000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (i < 4 && bus.dac_out !== 14'sd0) begin
                errors++; $display("FAIL latency early clk%0d: got %0d expected 0", i, bus.dac_out);
            end else if (i == 4 && bus.dac_out !== 14'sh0400) begin
                errors++; $display("FAIL latency dac_out: got %0h expected 0400", bus.dac_out);
            end
        end
        $display("test_latency done");
    endtask

    task automatic test_saturation();
        bus.y_in = 16'sd30000; bus.offset = 16'sd5000; bus.lim_hi = 16'sd20000;
        repeat (2) tick();
        checks += 2;
        if (bus.sat_hi !== 1'b1) begin errors++; $display("FAIL sat_hi set: got %0b expected 1", bus.sat_hi); end
        if (bus.sat_lo !== 1'b0) begin errors++; $display("FAIL sat_lo idle: got %0b expected 0", bus.sat_lo); end
        repeat (2) tick();
        checks++;
        if (bus.dac_out !== 14'sd5000) begin errors++; $display("FAIL clamp_hi dac_out: got %0d expected 5000", bus.dac_out); end
        bus.sat_clr = 1'b1; tick(); bus.sat_clr = 1'b0;
        checks++;
        if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL sat_clr priority: got %0d expected 0", bus.sat_count); end
        repeat (10) tick();
        checks++;
        if (bus.sat_count !== 16'd10 || bus.sat_count !== 16'(m_cnt)) begin
            errors++; $display("FAIL sat_count 10: got %0d expected 10", bus.sat_count);
        end
        bus.sat_clr = 1'b1; tick(); bus.sat_clr = 1'b0;
        checks++;
        if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL sat_clr: got %0d expected 0", bus.sat_count); end
        bus.y_in = -16'sd30000; bus.offset = -16'sd5000; bus.lim_lo = -16'sd20000;
        repeat (2) tick();
        checks += 2;
        if (bus.sat_lo !== 1'b1) begin errors++; $display("FAIL sat_lo set: got %0b expected 1", bus.sat_lo); end
        if (bus.sat_hi !== 1'b0) begin errors++; $display("FAIL sat_hi clear: got %0b expected 0", bus.sat_hi); end
        repeat (2) tick();
        checks++;
        if (bus.dac_out !== -14'sd5000) begin errors++; $display("FAIL clamp_lo dac_out: got %0d expected -5000", bus.dac_out); end
        $display("test_saturation done");
    endtask

    task automatic test_slew_up();
        int exp_dac;
        bus.y_in = '0; bus.offset = '0; bus.lim_lo = -16'sd32767; bus.lim_hi = 16'sd32767;
        repeat (4) tick();
        bus.max_step = 16'd100; bus.y_in = 16'sd1000;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_dac = (k <= 3) ? 0 : ((25 * (k - 3) > 250) ? 250 : 25 * (k - 3));
            checks++;
            if (bus.dac_out !== 14'(exp_dac) || bus.dac_out !== 14'(m_dac)) begin
                errors++; $display("FAIL slew_up clk%0d: got %0d expected %0d", k, bus.dac_out, exp_dac);
            end
        end
        $display("test_slew_up done");
    endtask

    task automatic test_ramp_down();
        int n = 0;
        int prev;
        int delta;
        bus.enable = 1'b0;
        while (bus.state !== 2'd0 && n < 40) begin
            tick();
            n++;
            checks++;
            if (bus.dac_out !== 14'(m_dac)) begin
                errors++; $display("FAIL ramp_down clk%0d: got %0d expected %0d", n, bus.dac_out, m_dac);
            end
        end
        checks += 2;
        if (bus.state !== 2'd0) begin errors++; $display("FAIL ramp_down timeout state: got %0d expected 0", bus.state); end
        if (bus.dac_out !== 14'sd0) begin errors++; $display("FAIL ramp_down final dac: got %0d expected 0", bus.dac_out); end
        bus.enable = 1'b1;
        repeat (14) tick();
        bus.enable = 1'b0;
        n = 0;
        while (m_acc != 500 && n < 20) begin tick(); n++; end
        checks++;
        if (m_acc != 500) begin errors++; $display("FAIL ramp_down reach500: got %0d expected 500", m_acc); end
        bus.enable = 1'b1;
        prev = m_dac;
        for (int k = 1; k <= 10; k++) begin
            tick();
            delta = int'(bus.dac_out) - prev;
            prev  = int'(bus.dac_out);
            checks += 2;
            if (bus.dac_out !== 14'(m_dac)) begin
                errors++; $display("FAIL resume clk%0d: got %0d expected %0d", k, bus.dac_out, m_dac);
            end
            if (delta > 25 || delta < -25) begin
                errors++; $display("FAIL resume jump clk%0d: got step %0d expected |step|<=25", k, delta);
            end
        end
        checks++;
        if (bus.state !== 2'd1) begin errors++; $display("FAIL resume state: got %0d expected 1", bus.state); end
        $display("test_ramp_down done");
    endtask

    task automatic test_hold();
        repeat (6) tick();
        bus.hold = 1'b1; bus.y_in = -16'sd1000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (bus.dac_out !== 14'sd250) begin
                errors++; $display("FAIL hold clk%0d: got %0d expected 250", k, bus.dac_out);
            end
        end
        bus.hold = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (bus.dac_out !== 14'(m_dac) || (k == 2 && bus.dac_out !== 14'sd225)) begin
                errors++; $display("FAIL hold_release clk%0d: got %0d expected %0d", k, bus.dac_out, m_dac);
            end
        end
        $display("test_hold done");
    endtask

    task automatic test_cfg_err();
        bus.lim_lo = 16'sd100; bus.lim_hi = -16'sd100; bus.y_in = 16'($urandom);
        repeat (2) tick();
        checks += 3;
        if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err: got %0b expected 1", bus.cfg_err); end
        if (bus.sat_hi !== 1'b0) begin errors++; $display("FAIL cfg sat_hi: got %0b expected 0", bus.sat_hi); end
        if (bus.sat_lo !== 1'b0) begin errors++; $display("FAIL cfg sat_lo: got %0b expected 0", bus.sat_lo); end
        repeat (30) tick();
        checks++;
        if (bus.dac_out !== 14'sd0 || bus.dac_out !== 14'(m_dac)) begin
            errors++; $display("FAIL cfg slew_to_zero: got %0d expected 0", bus.dac_out);
        end
        bus.lim_lo = -16'sd32767; bus.lim_hi = 16'sd32767;
        $display("test_cfg_err done");
    endtask

    task automatic test_random();
        int v;
        for (int c = 0; c < 400; c++) begin
            bus.y_in   = 16'($urandom);
            bus.offset = 16'($urandom_range(8000, 0)) - 16'sd4000;
            if ($urandom_range(49, 0) == 0) begin
                v = int'($urandom_range(32767, 0));
                bus.lim_lo = 16'(v); bus.lim_hi = 16'(-v - 1);
            end else if ($urandom_range(19, 0) == 0) begin
                bus.lim_lo = 16'(-int'($urandom_range(32768, 0)));
                bus.lim_hi = 16'($urandom_range(32767, 0));
            end
            if ($urandom_range(9, 0) == 0) bus.max_step = 16'($urandom_range(3000, 0));
            if ($urandom_range(24, 0) == 0) bus.enable = ~bus.enable;
            bus.hold    = ($urandom_range(9, 0) == 0);
            bus.sat_clr = ($urandom_range(29, 0) == 0);
            tick();
            checks += 6;
            if (bus.dac_out !== 14'(m_dac)) begin errors++; $display("FAIL rand%0d dac_out: got %0d expected %0d", c, bus.dac_out, m_dac); end
            if (bus.state !== 2'(m_state)) begin errors++; $display("FAIL rand%0d state: got %0d expected %0d", c, bus.state, m_state); end
            if (bus.sat_hi !== m_sh) begin errors++; $display("FAIL rand%0d sat_hi: got %0b expected %0b", c, bus.sat_hi, m_sh); end
            if (bus.sat_lo !== m_sl) begin errors++; $display("FAIL rand%0d sat_lo: got %0b expected %0b", c, bus.sat_lo, m_sl); end
            if (bus.cfg_err !== m_cfg) begin errors++; $display("FAIL rand%0d cfg_err: got %0b expected %0b", c, bus.cfg_err, m_cfg); end
            if (bus.sat_count !== 16'(m_cnt)) begin errors++; $display("FAIL rand%0d sat_count: got %0d expected %0d", c, bus.sat_count, m_cnt); end
        end
        bus.hold = 1'b0; bus.sat_clr = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_reset_mid_ramp();
        bus.lim_lo = -16'sd32767; bus.lim_hi = 16'sd32767; bus.offset = '0;
        bus.max_step = 16'd50; bus.y_in = 16'sd8000; bus.enable = 1'b1;
        repeat (30) tick();
        bus.enable = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.state !== 2'd2) begin errors++; $display("FAIL pre_reset state: got %0d expected 2", bus.state); end
        rst = 1'b1;
        #2;
        checks += 3;
        if (bus.dac_out !== 14'sd0) begin errors++; $display("FAIL async_reset dac_out: got %0d expected 0", bus.dac_out); end
        if (bus.state !== 2'd0) begin errors++; $display("FAIL async_reset state: got %0d expected 0", bus.state); end
        if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL async_reset sat_count: got %0d expected 0", bus.sat_count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (3) tick();
        checks += 2;
        if (bus.state !== 2'd0) begin errors++; $display("FAIL post_reset state: got %0d expected 0", bus.state); end
        if (bus.dac_out !== 14'sd0) begin errors++; $display("FAIL post_reset dac_out: got %0d expected 0", bus.dac_out); end
        $display("test_reset_mid_ramp done");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_saturation();
        test_slew_up();
        test_ramp_down();
        test_hold();
        test_cfg_err();
        test_random();
        test_reset_mid_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_dac_output_stage.md
Name: iir_dac_output_stage

Overview:
- Downstream neighbour of the 2nd-order IIR filter. Takes the filter's 16-bit signed y_out, adds a programmable offset and clamps to a programmable window.
- Applies a per-clock slew-rate limit, then drives the 14-bit signed DAC word.
- An enable-driven state machine ramps the output up from zero and back down to zero, so enabling or disabling the loop never steps the actuator.
- Offset, limits, step and enable come from GPIO, in the same way as the filter coefficients.

Parameters:
- DATA_WIDTH, 16, width of y_in, offset, limits and the internal slew accumulator.
- OUT_WIDTH, 14, DAC word width; must be <= DATA_WIDTH.
- STEP_WIDTH, 16, width of the unsigned max_step.
- CNT_WIDTH, 16, width of the saturation counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- y_in  in  DATA_WIDTH  signed filter output, sampled every clock
- offset  in  DATA_WIDTH  signed offset added to y_in
- lim_lo  in  DATA_WIDTH  signed lower clamp bound
- lim_hi  in  DATA_WIDTH  signed upper clamp bound
- max_step  in  STEP_WIDTH  unsigned max |change| of acc per clock; 0 = unlimited
- enable  in  1  run request (level)
- hold  in  1  freeze acc at its current value (any state except IDLE)
- sat_clr  in  1  synchronous clear of sat_count
- dac_out  out  OUT_WIDTH  signed DAC word
- state  out  2  0 IDLE, 1 RUN, 2 RAMP_DOWN
- sat_hi  out  1  clamp at upper bound active this cycle (RUN only)
- sat_lo  out  1  clamp at lower bound active this cycle (RUN only)
- cfg_err  out  1  lim_lo > lim_hi
- sat_count  out  CNT_WIDTH  saturating count of clocks with sat_hi|sat_lo

Behaviour:
- Reset: all outputs 0; state IDLE; all pipeline registers and acc 0.
- Pipeline (all registered):
  - S1: sum = sign-extended y_in + offset, computed in DATA_WIDTH+1 bits; no wrap.
  - S2: tgt = clamp(sum, lim_lo, lim_hi); the comparisons use DATA_WIDTH+1 bits.
    - If lim_lo > lim_hi: tgt = 0 and cfg_err = 1; sat_hi and sat_lo both 0.
    - sat_hi and sat_lo are registered together with tgt.
  - S3: slew accumulator acc.
    - d = eff_tgt - acc, computed in DATA_WIDTH+2 bits.
    - If max_step == 0, or |d| <= max_step: acc = eff_tgt; otherwise acc = acc ± max_step.
    - hold = 1 leaves acc unchanged.
  - S4: dac_out = acc >>> (DATA_WIDTH-OUT_WIDTH), arithmetic shift, registered.
- Latency: y_in to dac_out is 4 clocks with max_step = 0 and enable steady in RUN.
- eff_tgt:
  - RUN: tgt.
  - IDLE and RAMP_DOWN: 0.
- State machine (registered; transitions take effect at the next edge):
  - IDLE: acc forced to 0; hold is ignored. enable = 1 -> RUN. Ramp-up from 0 is provided by the slew limiter.
  - RUN: enable = 0 -> RAMP_DOWN.
  - RAMP_DOWN: enable = 1 -> RUN, resuming from the current acc with no jump. acc == 0 with enable = 0 -> IDLE. hold = 1 stalls the ramp indefinitely.
  - A stale tgt in the S2 pipeline when entering RUN is acceptable; slew still applies.
- sat_hi and sat_lo are 0 outside RUN.
- sat_count:
  - Increments when sat_hi|sat_lo; saturates at all-ones.
  - sat_clr has priority over an increment in the same cycle.
- Config inputs are used directly and are assumed quasi-static (GPIO). No double registering is required beyond S2/S3 sampling.
- Reset asserted mid-ramp: immediate return to IDLE, dac_out = 0, without ramping.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_RAMP_DOWN) and a helper function for the signed clamp.
- One natural sub-module: slew_limiter, covering acc, hold and max_step, and parameterised by DATA_WIDTH and STEP_WIDTH.
- The FSM, offset/clamp and output shift stay in the top level.

Test Plan:
- Reset, then enable=1, max_step=0, offset=0, limits ±32767, y_in=16'h1000 -> state RUN; dac_out = 14'h0400 exactly 4 clocks after y_in is applied (after the RUN transition).
- y_in=30000, offset=5000, lim_hi=20000 -> tgt 20000, sat_hi=1, dac_out=5000; 10 clocks later sat_count=10; pulse sat_clr -> sat_count=0 the next clock.
- max_step=100, RUN, y_in steps 0 -> 1000 -> acc rises by 100 per clock; dac_out ramps 0, 25, 50 … 250, reaching 250 after 10 steps.
- From acc=1000 with max_step=100, drop enable -> RAMP_DOWN; acc falls by 100 per clock; after 10 clocks IDLE with dac_out=0. Re-asserting enable at acc=500 -> RUN, and acc climbs from 500 with no jump.
- hold=1 in RUN with tgt changing -> dac_out constant. Release hold -> slew resumes from the held value.
- lim_lo=100, lim_hi=-100 -> cfg_err=1, sat_hi=sat_lo=0, acc slews to 0. Separately, assert rst mid-ramp -> all outputs 0 immediately.
